// File: rtl/i2c_dac_pkg.sv
// Shared types and constants for the I2C DAC write target.
package i2c_dac_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ACK_A,
      ST_CMD,
      ST_ACK_C,
      ST_DATA_HI,
      ST_ACK_H,
      ST_DATA_LO,
      ST_ACK_L,
      ST_DONE,
      ST_IGNORE
   } state_t;

   localparam logic [4:0] CMD_PREFIX   = 5'b00001;
   localparam logic [6:0] DEF_DEV_ADDR = 7'h2A;
   localparam int         DEF_CODE_W   = 12;

   // Only the low nibble of the HI byte carries code bits.
   localparam int HI_NIB_MSB = 3;
   localparam int HI_NIB_LSB = 0;

   // States where a START/STOP abandons a partially received frame.
   function automatic logic in_frame(input state_t s);
      return !(s inside {ST_IDLE, ST_DONE, ST_IGNORE});
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers plus START/STOP and SCL edge strobes.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_s,
   output logic start,
   output logic stop,
   output logic scl_rise,
   output logic scl_fall
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_s;
   logic                   scl_d;
   logic                   sda_d;

   // Reset to the idle bus level so releasing reset never fakes an edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end

   assign scl_s    = scl_sync[SYNC_STAGES-1];
   assign sda_s    = sda_sync[SYNC_STAGES-1];
   assign start    = scl_s & scl_d & sda_d & ~sda_s;
   assign stop     = scl_s & scl_d & ~sda_d & sda_s;
   assign scl_rise = scl_s & ~scl_d;
   assign scl_fall = ~scl_s & scl_d;

endmodule

// File: rtl/i2c_dac_target.sv
// Write-only I2C DAC target: frame decode, ACK drive, shadow/active code
// registers with level-sensitive LDAC transfer.
module i2c_dac_target
   import i2c_dac_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = DEF_DEV_ADDR,
   parameter int         NUM_CH      = 8,
   parameter int         CODE_W      = DEF_CODE_W,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       scl_i,
   input  logic                       sda_i,
   output logic                       sda_oe,
   input  logic                       ldac_n,
   output logic                       wr_valid,
   output logic [2:0]                 wr_ch,
   output logic [CODE_W-1:0]          wr_code,
   output logic                       frame_err,
   output logic                       busy,
   output logic [NUM_CH*CODE_W-1:0]   dac_code
);

   // state      | meaning
   // IDLE       | bus free, waiting for START
   // ADDR/CMD   | shifting address / command byte
   // DATA_HI/LO | shifting code bytes
   // ACK_x      | pulling SDA low for the ACK bit of the previous byte
   // DONE       | frame committed; any further byte is NACKed
   // IGNORE     | not addressed or rejected; wait for START/STOP

   state_t              state;
   state_t              state_nx;
   logic                sda_s;
   logic                start;
   logic                stop;
   logic                scl_rise;
   logic                scl_fall;
   logic [7:0]          shift;
   logic [2:0]          bit_cnt;
   logic                byte_rdy;
   logic [2:0]          ch_q;
   logic [3:0]          hi_q;
   logic                addr_ok;
   logic                cmd_ok;
   logic                shift_en;
   logic                commit;
   logic                err_evt;
   logic [CODE_W-1:0]   new_code;
   logic [SYNC_STAGES-1:0] ldac_sync;
   logic                ldac_s;
   logic [CODE_W-1:0]   shadow [NUM_CH];
   logic [CODE_W-1:0]   active [NUM_CH];

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
      .clk      (clk),
      .resetn   (resetn),
      .scl_i    (scl_i),
      .sda_i    (sda_i),
      .sda_s    (sda_s),
      .start    (start),
      .stop     (stop),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall)
   );

   assign addr_ok  = (shift == {DEV_ADDR, 1'b0});
   assign cmd_ok   = (shift[7:3] == CMD_PREFIX) && (int'(shift[2:0]) < NUM_CH);
   assign shift_en = state inside {ST_ADDR, ST_CMD, ST_DATA_HI, ST_DATA_LO, ST_DONE};
   assign new_code = {hi_q, shift};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (start) begin
         state_nx = ST_ADDR;
      end else if (stop) begin
         state_nx = ST_IDLE;
      end else if (scl_fall) begin
         case (state)
            ST_ADDR:    if (byte_rdy) state_nx = addr_ok ? ST_ACK_A : ST_IGNORE;
            ST_ACK_A:   state_nx = ST_CMD;
            ST_CMD:     if (byte_rdy) state_nx = cmd_ok ? ST_ACK_C : ST_IGNORE;
            ST_ACK_C:   state_nx = ST_DATA_HI;
            ST_DATA_HI: if (byte_rdy) state_nx = ST_ACK_H;
            ST_ACK_H:   state_nx = ST_DATA_LO;
            ST_DATA_LO: if (byte_rdy) state_nx = ST_ACK_L;
            ST_ACK_L:   state_nx = ST_DONE;
            ST_DONE:    if (byte_rdy) state_nx = ST_IGNORE;
            default:    state_nx = state;
         endcase
      end
   end

   // sda_oe decodes straight from the async-reset state register, so reset
   // releases the line without waiting for a clock.
   always_comb begin
      sda_oe  = state inside {ST_ACK_A, ST_ACK_C, ST_ACK_H, ST_ACK_L};
      busy    = (state != ST_IDLE);
      commit  = 1'b0;
      err_evt = 1'b0;
      if (start || stop) begin
         err_evt = in_frame(state);
      end else if (scl_fall) begin
         commit  = (state == ST_ACK_L);
         err_evt = byte_rdy && (((state == ST_CMD) && !cmd_ok) || (state == ST_DONE));
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shift    <= '0;
         bit_cnt  <= '0;
         byte_rdy <= 1'b0;
         ch_q     <= '0;
         hi_q     <= '0;
      end else if (start || stop) begin
         bit_cnt  <= '0;
         byte_rdy <= 1'b0;
      end else if (scl_rise && shift_en) begin
         shift   <= {shift[6:0], sda_s};
         bit_cnt <= bit_cnt + 3'd1;
         if (bit_cnt == 3'd7) byte_rdy <= 1'b1;
      end else if (scl_fall) begin
         byte_rdy <= 1'b0;
         if (byte_rdy && (state == ST_CMD))     ch_q <= shift[2:0];
         if (byte_rdy && (state == ST_DATA_HI)) hi_q <= shift[HI_NIB_MSB:HI_NIB_LSB];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_valid  <= 1'b0;
         frame_err <= 1'b0;
         wr_ch     <= '0;
         wr_code   <= '0;
         for (int n = 0; n < NUM_CH; n++) shadow[n] <= '0;
      end else begin
         wr_valid  <= commit;
         frame_err <= err_evt;
         if (commit) begin
            wr_ch        <= ch_q;
            wr_code      <= new_code;
            shadow[ch_q] <= new_code;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) ldac_sync <= '1;
      else         ldac_sync <= {ldac_sync[SYNC_STAGES-2:0], ldac_n};
   end

   assign ldac_s = ldac_sync[SYNC_STAGES-1];

   // Copy reads shadow before any same-cycle write lands.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int n = 0; n < NUM_CH; n++) active[n] <= '0;
      end else if (!ldac_s) begin
         for (int n = 0; n < NUM_CH; n++) active[n] <= shadow[n];
      end
   end

   for (genvar n = 0; n < NUM_CH; n++) begin : g_dac
      assign dac_code[n*CODE_W +: CODE_W] = active[n];
   end

endmodule

// File: tb/tb_i2c_dac_target.sv
// Directed bench for i2c_dac_target: table of frames plus corner sequences.
module tb_i2c_dac_target;

   localparam int Q = 10;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        scl_m = 1'b1;
   logic        sda_m = 1'b1;
   logic        ldac_n = 1'b1;
   logic        sda_bus;
   logic        sda_oe;
   logic        wr_valid;
   logic [2:0]  wr_ch;
   logic [11:0] wr_code;
   logic        frame_err;
   logic        busy;
   logic [95:0] dac_code;

   int          n_chk = 0;
   int          n_err = 0;
   int          wr_cnt = 0;
   int          err_cnt = 0;
   int          oe_cnt = 0;
   logic [2:0]  last_ch = '0;
   logic [11:0] last_code = '0;

   assign sda_bus = sda_m & ~sda_oe;

   i2c_dac_target dut (
      .clk       (clk),
      .resetn    (resetn),
      .scl_i     (scl_m),
      .sda_i     (sda_bus),
      .sda_oe    (sda_oe),
      .ldac_n    (ldac_n),
      .wr_valid  (wr_valid),
      .wr_ch     (wr_ch),
      .wr_code   (wr_code),
      .frame_err (frame_err),
      .busy      (busy),
      .dac_code  (dac_code)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_valid) begin
         wr_cnt++;
         last_ch   = wr_ch;
         last_code = wr_code;
      end
      if (frame_err) err_cnt++;
      if (sda_oe) oe_cnt++;
   end

   typedef struct {
      int              nb;
      logic [0:4][7:0] b;
      logic [4:0]      ack;
      int              wr;
      logic [2:0]      ch;
      logic [11:0]     code;
      int              err;
   } vec_t;

   vec_t vt [12];

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] ch_code(input int n);
      return dac_code[n*12 +: 12];
   endfunction

   task automatic i2c_start;
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      sda_m = 1'b0; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic i2c_stop;
      sda_m = 1'b0; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      sda_m = 1'b1; wait_clk(Q);
   endtask

   task automatic send_bits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; wait_clk(Q);
         scl_m = 1'b1; wait_clk(2*Q);
         scl_m = 1'b0; wait_clk(Q);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      send_bits(b);
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      ack = sda_oe;
      wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic ldac_pulse;
      ldac_n = 1'b0; wait_clk(4);
      ldac_n = 1'b1; wait_clk(4);
   endtask

   task automatic run_vec(input int i);
      logic a;
      int   wr0, err0, oe0;
      wr0 = wr_cnt; err0 = err_cnt; oe0 = oe_cnt;
      i2c_start;
      chk($sformatf("busy_mid v%0d", i), busy, 1);
      for (int k = 0; k < vt[i].nb; k++) begin
         send_byte(vt[i].b[k], a);
         chk($sformatf("ack v%0d b%0d", i, k), a, vt[i].ack[k]);
      end
      i2c_stop;
      wait_clk(8);
      chk($sformatf("busy_end v%0d", i), busy, 0);
      chk($sformatf("wr_cnt v%0d", i), wr_cnt - wr0, vt[i].wr);
      if (vt[i].wr > 0) begin
         chk($sformatf("wr_ch v%0d", i), last_ch, vt[i].ch);
         chk($sformatf("wr_code v%0d", i), last_code, vt[i].code);
      end
      chk($sformatf("err_cnt v%0d", i), err_cnt - err0, vt[i].err);
      chk($sformatf("oe_seen v%0d", i), (oe_cnt - oe0) != 0, vt[i].ack != 0);
   endtask

   initial begin
      logic a;
      int   wr0, err0;

      vt[0] = '{4, {8'h54, 8'h0A, 8'h05, 8'h20, 8'h00}, 5'b01111, 1, 3'd2, 12'h520, 0};
      vt[1] = '{4, {8'h56, 8'h0A, 8'h05, 8'h20, 8'h00}, 5'b00000, 0, 3'd0, 12'h000, 0};
      vt[2] = '{3, {8'h54, 8'h18, 8'h05, 8'h00, 8'h00}, 5'b00001, 0, 3'd0, 12'h000, 1};
      vt[3] = '{5, {8'h54, 8'h0F, 8'hFF, 8'hFF, 8'hAA}, 5'b01111, 1, 3'd7, 12'hFFF, 1};
      for (int n = 0; n < 8; n++)
         vt[4+n] = '{4, {8'h54, 8'h08 + 8'(n), 8'(n), 8'(n), 8'h00}, 5'b01111, 1,
                     3'(n), 12'(n * 12'h101), 0};

      wait_clk(5);
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wr_valid", wr_valid, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_codes", dac_code == '0, 1);
      resetn = 1'b1;
      wait_clk(5);

      for (int i = 0; i < 12; i++) begin
         run_vec(i);
         if (i == 0) begin
            chk("ch2_held", ch_code(2), 12'h000);
            ldac_n = 1'b0;
            wait_clk(3);
            chk("ch2_ldac", ch_code(2), 12'h520);
            ldac_n = 1'b1;
            wait_clk(4);
         end
         if (i == 3) begin
            ldac_pulse;
            chk("ch0_untouched", ch_code(0), 12'h000);
            chk("ch2_kept", ch_code(2), 12'h520);
            chk("ch7_extra", ch_code(7), 12'hFFF);
         end
      end

      // All eight channels must switch on the same clock.
      ldac_n = 1'b0;
      wait_clk(2);
      for (int n = 0; n < 8; n++)
         chk($sformatf("pre_ldac ch%0d", n), ch_code(n),
             (n == 2) ? 12'h520 : (n == 7) ? 12'hFFF : 12'h000);
      wait_clk(1);
      for (int n = 0; n < 8; n++)
         chk($sformatf("post_ldac ch%0d", n), ch_code(n), 12'(n * 12'h101));
      ldac_n = 1'b1;
      wait_clk(4);

      // Repeated START during the LO byte, then a clean frame to channel 0.
      wr0 = wr_cnt; err0 = err_cnt;
      i2c_start;
      send_byte(8'h54, a); chk("rs_ack_addr", a, 1);
      send_byte(8'h09, a); chk("rs_ack_cmd", a, 1);
      send_byte(8'h0F, a); chk("rs_ack_hi", a, 1);
      i2c_start;
      send_byte(8'h54, a); chk("rs2_ack_addr", a, 1);
      send_byte(8'h08, a); chk("rs2_ack_cmd", a, 1);
      send_byte(8'h0A, a); chk("rs2_ack_hi", a, 1);
      send_byte(8'hBC, a); chk("rs2_ack_lo", a, 1);
      i2c_stop;
      wait_clk(8);
      chk("rs_err_cnt", err_cnt - err0, 1);
      chk("rs_wr_cnt", wr_cnt - wr0, 1);
      chk("rs_wr_ch", last_ch, 0);
      chk("rs_wr_code", last_code, 12'hABC);
      ldac_pulse;
      chk("rs_ch0", ch_code(0), 12'hABC);
      chk("rs_ch1", ch_code(1), 12'h101);

      // Reset while acknowledging the command byte.
      i2c_start;
      send_byte(8'h54, a); chk("rst_ack_addr", a, 1);
      send_bits(8'h0B);
      wait_clk(Q);
      chk("ack_c_oe", sda_oe, 1);
      #3 resetn = 1'b0;
      #1 chk("async_oe", sda_oe, 0);
      chk("async_busy", busy, 0);
      chk("async_codes", dac_code == '0, 1);
      scl_m = 1'b1;
      sda_m = 1'b1;
      wait_clk(3);
      resetn = 1'b1;
      wait_clk(5);
      wr0 = wr_cnt;
      i2c_start;
      send_byte(8'h54, a); chk("post_rst_ack0", a, 1);
      send_byte(8'h0C, a); chk("post_rst_ack1", a, 1);
      send_byte(8'h01, a); chk("post_rst_ack2", a, 1);
      send_byte(8'h23, a); chk("post_rst_ack3", a, 1);
      i2c_stop;
      wait_clk(8);
      chk("post_rst_wr", wr_cnt - wr0, 1);
      ldac_pulse;
      chk("post_rst_ch4", ch_code(4), 12'h123);
      chk("post_rst_ch0", ch_code(0), 12'h000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
